// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - fetch/data bus, datapath control and status bundle of the core sequencer
interface core_seq_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
);
    logic                  ibus_req;
    logic [XLEN-1:0]       ibus_addr;
    logic                  ibus_ack;
    logic [INST_WIDTH-1:0] ibus_rdata;
    logic                  dbus_req;
    logic                  dbus_we;
    logic                  dbus_ack;
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  exec;
    logic                  is_load;
    logic                  is_store;
    logic                  dp_regfile_we;
    logic                  dp_csr_we;
    logic                  trap_req;
    logic [XLEN-1:0]       next_pc;
    logic [XLEN-1:0]       mtvec;
    logic                  regfile_we;
    logic                  csr_we;
    logic                  trap_commit;
    logic                  retire;
    logic [CNT_WIDTH-1:0]  instret;
    logic                  bus_fault;
    logic [1:0]            bus_fault_cause;
    logic [XLEN-1:0]       bus_fault_addr;

    modport master (
        output ibus_req, ibus_addr, dbus_req, dbus_we, pc, inst, exec,
        output regfile_we, csr_we, trap_commit, retire, instret,
        output bus_fault, bus_fault_cause, bus_fault_addr,
        input  ibus_ack, ibus_rdata, dbus_ack, is_load, is_store,
        input  dp_regfile_we, dp_csr_we, trap_req, next_pc, mtvec
    );

    modport slave (
        input  ibus_req, ibus_addr, dbus_req, dbus_we, pc, inst, exec,
        input  regfile_we, csr_we, trap_commit, retire, instret,
        input  bus_fault, bus_fault_cause, bus_fault_addr,
        output ibus_ack, ibus_rdata, dbus_ack, is_load, is_store,
        output dp_regfile_we, dp_csr_we, trap_req, next_pc, mtvec
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle FETCH/EXEC/MEM sequencer with gated commits and bus timeouts
module core_seq_ctrl #(
    parameter int              XLEN           = 32,
    parameter int              INST_WIDTH     = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
    parameter int              TIMEOUT_CYCLES = 16,
    parameter int              CNT_WIDTH      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    core_seq_ctrl_if.master      bus
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;

    localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int            TLIM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TLIM   = TW'(TLIM_I);

    logic [1:0]            state;
    logic [XLEN-1:0]       pc_q;
    logic [INST_WIDTH-1:0] ir;
    logic [CNT_WIDTH-1:0]  instret_q;
    logic [TW-1:0]         tcnt;
    logic                  fault_q;
    logic [1:0]            cause_q;
    logic [XLEN-1:0]       fault_addr_q;

    logic in_fetch, in_exec, in_mem, waiting, ack, timeout;
    logic exec_trap, exec_retire, mem_done, retire;

    assign in_fetch = (state == S_FETCH);
    assign in_exec  = (state == S_EXEC);
    assign in_mem   = (state == S_MEM);
    assign waiting  = in_fetch | in_mem;
    assign ack      = in_fetch ? bus.ibus_ack : bus.dbus_ack;

    // The last waiting cycle faults only if no ack arrives in it; a late ack still wins.
    assign timeout  = (TIMEOUT_CYCLES != 0) && waiting && !ack && (tcnt == TLIM);

    assign exec_trap   = in_exec & bus.trap_req;
    assign exec_retire = in_exec & ~bus.trap_req & ~(bus.is_load | bus.is_store);
    assign mem_done    = in_mem & bus.dbus_ack;
    assign retire      = exec_retire | mem_done;

    // Requests are masked by rst so an in-flight access drops without waiting for a clock.
    assign bus.ibus_req        = in_fetch & ~rst;
    assign bus.ibus_addr       = pc_q;
    assign bus.dbus_req        = in_mem & ~rst;
    assign bus.dbus_we         = in_mem & ~rst & bus.is_store;
    assign bus.pc              = pc_q;
    assign bus.inst            = ir;
    assign bus.exec            = in_exec;
    assign bus.regfile_we      = (exec_retire & bus.dp_regfile_we)
                               | (mem_done & bus.dp_regfile_we & bus.is_load);
    assign bus.csr_we          = exec_retire & bus.dp_csr_we;
    assign bus.trap_commit     = exec_trap;
    assign bus.retire          = retire;
    assign bus.instret         = instret_q;
    assign bus.bus_fault       = fault_q;
    assign bus.bus_fault_cause = cause_q;
    assign bus.bus_fault_addr  = fault_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            ir           <= '0;
            instret_q    <= '0;
            tcnt         <= '0;
            fault_q      <= 1'b0;
            cause_q      <= 2'd0;
            fault_addr_q <= '0;
        end else begin
            fault_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.ibus_ack) begin
                        ir    <= bus.ibus_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.trap_req || !(bus.is_load || bus.is_store)) begin
                        pc_q  <= bus.next_pc;
                        state <= S_FETCH;
                    end else begin
                        state <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (bus.dbus_ack) begin
                        pc_q  <= bus.next_pc;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase

            if (timeout) begin
                state        <= S_FETCH;
                pc_q         <= bus.mtvec;
                fault_q      <= 1'b1;
                cause_q      <= in_fetch ? 2'd0 : (bus.is_store ? 2'd2 : 2'd1);
                fault_addr_q <= pc_q;
            end

            if (retire) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end

            // Any state change (ack, timeout, leaving EXEC) restarts the wait count.
            if (waiting && !ack && !timeout) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl
`timescale 1ns/1ps
module tb_core_seq_ctrl;
    localparam int          XLEN = 32;
    localparam int          IW   = 32;
    localparam int          CW   = 4;
    localparam int          TMO  = 4;
    localparam logic [31:0] RV   = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_seq_ctrl_if #(.XLEN(XLEN), .INST_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    core_seq_ctrl #(
        .XLEN(XLEN), .INST_WIDTH(IW), .RESET_VECTOR(RV),
        .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        bit trap, ld, st, rfwe, csrwe;
        int flat, dlat;
        bit e_rfwe, e_csrwe, e_tc, e_ret, e_mem;
    } vec_t;

    vec_t vecs[8];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc, m_ir, m_faddr, mtvec_v;
    logic [1:0]  m_cause;
    int          m_instret;
    bit          fault_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ibus_ack      = 1'b0;
        bus.ibus_rdata    = '0;
        bus.dbus_ack      = 1'b0;
        bus.is_load       = 1'b0;
        bus.is_store      = 1'b0;
        bus.dp_regfile_we = 1'b0;
        bus.dp_csr_we     = 1'b0;
        bus.trap_req      = 1'b0;
        bus.next_pc       = '0;
        bus.mtvec         = mtvec_v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic common();
        chk("pc", bus.pc, m_pc);
        chk("instret", bus.instret, 64'(m_instret % 16));
        chk("bus_fault", bus.bus_fault, fault_exp);
        chk("fault_cause", bus.bus_fault_cause, m_cause);
        chk("fault_addr", bus.bus_fault_addr, m_faddr);
        fault_exp = 1'b0;
    endtask

    task automatic fault(input logic [1:0] cause);
        m_cause   = cause;
        m_faddr   = m_pc;
        m_pc      = mtvec_v;
        fault_exp = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ibus_req", bus.ibus_req, 0);
        chk("rst_dbus_req", bus.dbus_req, 0);
        chk("rst_pc", bus.pc, RV);
        chk("rst_instret", bus.instret, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_exec", bus.exec, 0);
        chk("rst_fault", bus.bus_fault, 0);
        chk("rst_cause", bus.bus_fault_cause, 0);
        chk("rst_faddr", bus.bus_fault_addr, 0);
        next_cycle();
        rst       = 1'b0;
        m_pc      = RV;
        m_ir      = '0;
        m_instret = 0;
        m_cause   = 2'd0;
        m_faddr   = '0;
        fault_exp = 1'b0;
        clear_inputs();
    endtask

    task automatic fetch_phase(input int lat, input logic [31:0] inst, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < TMO && !ok; c++) begin
            bus.ibus_ack   = (c == lat);
            bus.ibus_rdata = (c == lat) ? inst : $urandom;
            #1;
            common();
            chk("ibus_req", bus.ibus_req, 1);
            chk("ibus_addr", bus.ibus_addr, m_pc);
            chk("fetch_ir", bus.inst, m_ir);
            chk("fetch_exec", bus.exec, 0);
            chk("fetch_retire", bus.retire, 0);
            chk("fetch_dbus_req", bus.dbus_req, 0);
            next_cycle();
            if (c == lat) begin
                ok   = 1'b1;
                m_ir = inst;
            end
        end
        bus.ibus_ack = 1'b0;
        if (!ok) fault(2'd0);
    endtask

    task automatic exec_phase(input bit trap, ld, st, rfwe, csrwe, input logic [31:0] npc,
                              input bit e_rfwe, e_csrwe, e_tc, e_ret);
        bus.trap_req      = trap;
        bus.is_load       = ld;
        bus.is_store      = st;
        bus.dp_regfile_we = rfwe;
        bus.dp_csr_we     = csrwe;
        bus.next_pc       = npc;
        #1;
        common();
        chk("exec", bus.exec, 1);
        chk("exec_inst", bus.inst, m_ir);
        chk("exec_ibus_req", bus.ibus_req, 0);
        chk("exec_dbus_req", bus.dbus_req, 0);
        chk("exec_regfile_we", bus.regfile_we, e_rfwe);
        chk("exec_csr_we", bus.csr_we, e_csrwe);
        chk("exec_trap_commit", bus.trap_commit, e_tc);
        chk("exec_retire", bus.retire, e_ret);
        next_cycle();
        if (e_tc || e_ret) m_pc = npc;
        if (e_ret) m_instret++;
    endtask

    task automatic mem_phase(input int lat, input bit ld, st, rfwe, input logic [31:0] npc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < TMO && !ok; c++) begin
            bus.dbus_ack = (c == lat);
            #1;
            common();
            chk("mem_dbus_req", bus.dbus_req, 1);
            chk("mem_dbus_we", bus.dbus_we, st);
            chk("mem_ibus_req", bus.ibus_req, 0);
            chk("mem_exec", bus.exec, 0);
            chk("mem_regfile_we", bus.regfile_we, (c == lat) && ld && rfwe);
            chk("mem_csr_we", bus.csr_we, 0);
            chk("mem_retire", bus.retire, c == lat);
            chk("mem_trap_commit", bus.trap_commit, 0);
            next_cycle();
            if (c == lat) begin
                ok   = 1'b1;
                m_pc = npc;
                m_instret++;
            end
        end
        bus.dbus_ack = 1'b0;
        if (!ok) fault(st ? 2'd2 : 2'd1);
    endtask

    task automatic run_instr(input int flat, input logic [31:0] inst,
                             input bit trap, ld, st, rfwe, csrwe,
                             input logic [31:0] npc, input int dlat);
        bit ok, e_mem, e_ret;
        fetch_phase(flat, inst, ok);
        if (ok) begin
            e_mem = !trap && (ld || st);
            e_ret = !trap && !e_mem;
            exec_phase(trap, ld, st, rfwe, csrwe, npc, e_ret && rfwe, e_ret && csrwe, trap, e_ret);
            if (e_mem) mem_phase(dlat, ld, st, rfwe, npc);
        end
        clear_inputs();
    endtask

    initial begin
        bit          ok;
        int          k, saved_ret;
        logic [31:0] npc;

        vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[1] = '{0, 0, 0, 0, 1, 3, 0, 0, 1, 0, 1, 0};
        vecs[2] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 1, 0};
        vecs[3] = '{0, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 1};
        vecs[4] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1};
        vecs[5] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[6] = '{1, 1, 0, 1, 1, 2, 0, 0, 0, 1, 0, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        mtvec_v = 32'h100;
        clear_inputs();
        do_reset();

        for (int i = 0; i < 8; i++) begin
            fetch_phase(vecs[i].flat, 32'h0010_0093 + 32'(i), ok);
            npc = m_pc + 32'd4;
            exec_phase(vecs[i].trap, vecs[i].ld, vecs[i].st, vecs[i].rfwe, vecs[i].csrwe, npc,
                       vecs[i].e_rfwe, vecs[i].e_csrwe, vecs[i].e_tc, vecs[i].e_ret);
            if (i == 0) begin
                chk("addi_pc", bus.pc, 32'h4);
                chk("addi_instret", bus.instret, 1);
            end
            if (vecs[i].e_mem) mem_phase(vecs[i].dlat, vecs[i].ld, vecs[i].st, vecs[i].rfwe, npc);
            clear_inputs();
        end

        run_instr(0, 32'h0000_0013, 0, 0, 0, 0, 0, 32'h40, 0);
        saved_ret = m_instret;
        run_instr(0, 32'h0000_2083, 0, 1, 0, 1, 0, 32'h44, 99);
        chk("to_fault_pulse", bus.bus_fault, 1);
        chk("to_fault_cause", bus.bus_fault_cause, 1);
        chk("to_fault_addr", bus.bus_fault_addr, 32'h40);
        chk("to_fault_pc", bus.pc, 32'h100);
        chk("to_no_retire", bus.instret, 64'(saved_ret % 16));
        run_instr(0, 32'h0000_2083, 0, 1, 0, 1, 0, 32'h200, TMO - 1);
        chk("late_ack_pc", bus.pc, 32'h200);
        chk("late_ack_no_fault", bus.bus_fault, 0);

        fetch_phase(0, 32'h0000_2103, ok);
        exec_phase(0, 1, 0, 1, 0, 32'h204, 0, 0, 0, 0);
        bus.dbus_ack = 1'b0;
        #1;
        chk("pre_rst_dbus_req", bus.dbus_req, 1);
        do_reset();

        for (int i = 0; i < 16; i++) run_instr(0, 32'h0000_0013, 0, 0, 0, 0, 0, m_pc + 32'd4, 0);
        chk("instret_wrap", bus.instret, 0);
        chk("wrap_pc", bus.pc, 32'd64);

        for (int n = 0; n < 200; n++) begin
            if (n % 16 == 0) begin
                mtvec_v   = $urandom & 32'hFFFF_FFFC;
                bus.mtvec = mtvec_v;
            end
            k = $urandom_range(0, 7);
            run_instr($urandom_range(0, 4), $urandom, k == 0, k == 1 || k == 2, k == 3 || k == 4,
                      1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4));
        end
        #1;
        common();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32 core. It replaces the single-cycle assumption that imem and dmem answer combinationally.
- Holds the PC and the instruction register (IR), and drives fetch and data buses with req/ack handshakes of arbitrary latency.
- Gates the datapath's write enables (regfile, CSR, dmem, trap commit) so state changes only at commit.
- Counts retired instructions and converts bus timeouts into access-fault traps.

Parameters:
- XLEN, 32, datapath/address width.
- INST_WIDTH, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum cycles a bus request may wait for ack; 0 disables the timeout.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_ibus_req  out  1  fetch request.
- o_ibus_addr  out  XLEN  fetch address (equals o_pc).
- i_ibus_ack  in  1  fetch data valid this cycle.
- i_ibus_rdata  in  INST_WIDTH  fetched instruction.
- o_dbus_req  out  1  data request.
- o_dbus_we  out  1  data request is a store.
- i_dbus_ack  in  1  data access completes this cycle; load data valid.
- o_pc  out  XLEN  architectural PC.
- o_inst  out  INST_WIDTH  IR contents.
- o_exec  out  1  high in EXEC; IR is decoded by the datapath.
- i_is_load  in  1  decoded instruction is a load.
- i_is_store  in  1  decoded instruction is a store.
- i_regfile_we  in  1  datapath regfile write enable (ungated).
- i_csr_we  in  1  datapath CSR write enable (ungated).
- i_trap_req  in  1  trap dispatch requests a trap for the IR.
- i_next_pc  in  XLEN  resolved next PC (branch/jump/trap/mret muxing done externally).
- i_mtvec  in  XLEN  trap vector, used on bus fault.
- o_regfile_we  out  1  gated regfile write.
- o_csr_we  out  1  gated CSR write.
- o_trap_commit  out  1  one-cycle pulse; trap state (CSR/trap_control) may update.
- o_retire  out  1  one-cycle pulse per retired instruction.
- o_instret  out  CNT_WIDTH  retired-instruction count.
- o_bus_fault  out  1  one-cycle timeout pulse.
- o_bus_fault_cause  out  2  0 = fetch, 1 = load, 2 = store; 3 is reserved.
- o_bus_fault_addr  out  XLEN  address of the timed-out access.

Behaviour:
- States: FETCH, EXEC, MEM.
- Reset (async, immediate): state = FETCH, o_pc = RESET_VECTOR, IR = 0, o_instret = 0, timeout counter = 0. All req/we/pulse outputs = 0. o_bus_fault_cause = 0, o_bus_fault_addr = 0. Any in-flight request drops immediately.
- FETCH:
  - o_ibus_req = 1 and is held until ack.
  - A first-cycle ack is legal (zero wait).
  - On ack: IR <= i_ibus_rdata; state -> EXEC.
- EXEC (exactly one cycle):
  - i_trap_req = 1: o_trap_commit = 1; o_regfile_we = o_csr_we = 0; no retire; PC <= i_next_pc; -> FETCH. Trap has priority over load/store/writes.
  - i_is_load or i_is_store: -> MEM. PC and IR are held.
  - Otherwise: o_regfile_we = i_regfile_we; o_csr_we = i_csr_we; retire; PC <= i_next_pc; -> FETCH. mret retires.
- MEM:
  - o_dbus_req = 1; o_dbus_we = i_is_store.
  - On ack: o_regfile_we = i_regfile_we & i_is_load; retire; PC <= i_next_pc; -> FETCH.
  - Datapath inputs stay stable in MEM because the IR is held.
- Retire: o_retire = 1 for one cycle; o_instret increments mod 2^CNT_WIDTH (wraps to 0).
- Gated write enables are 0 in every state except as listed above. o_csr_we is never asserted in MEM.
- Timeout:
  - The counter is cleared on entry to FETCH or MEM and increments each cycle req is high without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: req drops; o_bus_fault = 1 for one cycle; cause and addr are latched (PC for fetch, i_next_pc-independent latched o_pc for data; the datapath's LSU address is not visible, so addr = o_pc); PC <= i_mtvec; no retire; -> FETCH.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no fault.
- o_bus_fault_* hold their values until the next fault or reset.

Test Plan:
- Reset at PC 0, zero-wait ibus, ADDI in EXEC with i_next_pc = 4 -> FETCH, EXEC, FETCH; o_regfile_we = 1 in EXEC only; o_instret = 1; o_pc = 4.
- Fetch ack delayed 3 cycles -> o_ibus_req high 4 cycles; IR is loaded only at ack; no retire before EXEC.
- Load with dbus ack after 2 cycles -> o_dbus_req high 3 cycles, o_dbus_we = 0; o_regfile_we only in the ack cycle. Store -> o_dbus_we = 1 and o_regfile_we never asserted.
- i_trap_req with i_regfile_we = 1 and i_is_store = 1 -> o_trap_commit pulse; no regfile write; no MEM state; o_instret unchanged; PC = i_next_pc.
- TIMEOUT_CYCLES = 4, dbus never acks on a load at PC 0x40 -> fault after 4 waiting cycles; cause = 1; addr = 0x40; PC = i_mtvec; no retire. Repeat with ack in the timeout cycle -> normal completion, no fault.
- Assert i_rst mid-MEM -> o_dbus_req = 0 immediately; PC = RESET_VECTOR; o_instret = 0. CNT_WIDTH = 4 with 16 retires -> o_instret wraps to 0.
